// File: rtl/instr_mem_fetch_if.sv
// Fetch/load bundle between the IF stage (master) and the instruction memory (slave).
// Widths must match the parameters of the attached instr_mem_fetch instance.
interface instr_mem_fetch_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              fetch_en;
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              addr_fault;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic [CNT_W-1:0]  fetch_count;

    modport master (
        output fetch_en, stall, flush, address, load_en, load_addr, load_data,
        input  instruction, instr_valid, addr_fault, fetch_count
    );

    modport slave (
        input  fetch_en, stall, flush, address, load_en, load_addr, load_data,
        output instruction, instr_valid, addr_fault, fetch_count
    );
endinterface

// File: rtl/instr_mem_fetch.sv
// Synchronous-read instruction memory: one-cycle registered fetch with valid/fault tags and a load port.
// Stall holds all outputs, flush inserts a bubble; same-index load and fetch on one edge return the new word.
module instr_mem_fetch #(
    parameter int                 DATA_W    = 32,
    parameter int                 ADDR_W    = 32,
    parameter int                 DEPTH     = 64,
    parameter logic [DATA_W-1:0]  NOP_INSTR = 32'h0000_0000,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    instr_mem_fetch_if.slave   bus
);
    localparam int                IDX_W     = ADDR_W - 2;
    localparam int                MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  DEPTH_IDX = IDX_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              rd_legal;
    logic              wr_legal;
    logic [DATA_W-1:0] rd_word;
    logic [1:0]        unused_load_lsbs;

    logic [DATA_W-1:0] instruction_q, instruction_d;
    logic              instr_valid_q, instr_valid_d;
    logic              addr_fault_q,  addr_fault_d;
    logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

    assign rd_idx           = bus.address[ADDR_W-1:2];
    assign wr_idx           = bus.load_addr[ADDR_W-1:2];
    assign unused_load_lsbs = bus.load_addr[1:0];

    // Range checks use the full word index so high address bits can never alias into the array.
    always_comb begin
        rd_legal = (bus.address[1:0] == 2'b00) && (rd_idx < DEPTH_IDX);
        wr_legal = bus.load_en && (wr_idx < DEPTH_IDX);
        if (wr_legal && (wr_idx == rd_idx)) begin
            rd_word = bus.load_data;
        end else begin
            rd_word = mem[rd_idx[MEM_AW-1:0]];
        end
    end

    always_comb begin
        instruction_d = instruction_q;
        instr_valid_d = instr_valid_q;
        addr_fault_d  = addr_fault_q;
        fetch_count_d = fetch_count_q;
        if (bus.flush) begin
            instruction_d = NOP_INSTR;
            instr_valid_d = 1'b0;
            addr_fault_d  = 1'b0;
        end else if (!bus.stall) begin
            if (bus.fetch_en && rd_legal) begin
                instruction_d = rd_word;
                instr_valid_d = 1'b1;
                addr_fault_d  = 1'b0;
                if (fetch_count_q != CNT_MAX) begin
                    fetch_count_d = fetch_count_q + 1'b1;
                end
            end else begin
                instruction_d = NOP_INSTR;
                instr_valid_d = 1'b0;
                addr_fault_d  = bus.fetch_en;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instruction_q <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            addr_fault_q  <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
            addr_fault_q  <= addr_fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Program contents survive reset, so the array sits outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_legal) begin
            mem[wr_idx[MEM_AW-1:0]] <= bus.load_data;
        end
    end

    assign bus.instruction = instruction_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.addr_fault  = addr_fault_q;
    assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_instr_mem_fetch.sv
// Bench for instr_mem_fetch: directed scenarios plus randomized traffic against a word-array reference model.
module tb_instr_mem_fetch;
    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;

    instr_mem_fetch_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(16)) ifc ();
    instr_mem_fetch_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(2))  ifs ();

    // The narrow-counter instance sees exactly the same traffic.
    assign ifs.fetch_en  = ifc.fetch_en;
    assign ifs.stall     = ifc.stall;
    assign ifs.flush     = ifc.flush;
    assign ifs.address   = ifc.address;
    assign ifs.load_en   = ifc.load_en;
    assign ifs.load_addr = ifc.load_addr;
    assign ifs.load_data = ifc.load_data;

    instr_mem_fetch #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .NOP_INSTR(NOP), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    instr_mem_fetch #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .NOP_INSTR(NOP), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (ifs)
    );

    always #5 clk = ~clk;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] e_instr;
    logic        e_vld;
    logic        e_flt;
    int unsigned e_cnt;
    int unsigned e_cnt2;

    int tests = 0;
    int fails = 0;

    logic [31:0] prog [4];

    task automatic model_reset();
        e_instr = NOP;
        e_vld   = 1'b0;
        e_flt   = 1'b0;
        e_cnt   = 0;
        e_cnt2  = 0;
    endtask

    // Advance one clock: the model applies the current inputs, then outputs are sampled 1ns after the edge.
    task automatic step();
        int ra;
        int wa;
        ra = int'(ifc.address >> 2);
        wa = int'(ifc.load_addr >> 2);
        if (ifc.flush) begin
            e_instr = NOP; e_vld = 1'b0; e_flt = 1'b0;
        end else if (!ifc.stall) begin
            if (ifc.fetch_en && (ifc.address % 4 == 0) && (ra < DEPTH)) begin
                e_instr = (ifc.load_en && wa == ra) ? ifc.load_data : m_mem[ra[5:0]];
                e_vld   = 1'b1;
                e_flt   = 1'b0;
                if (e_cnt < 65535) e_cnt++;
                if (e_cnt2 < 3) e_cnt2++;
            end else begin
                e_instr = NOP; e_vld = 1'b0; e_flt = ifc.fetch_en;
            end
        end
        if (ifc.load_en && wa < DEPTH) m_mem[wa[5:0]] = ifc.load_data;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        ifc.fetch_en = 1'b0;
        ifc.stall    = 1'b0;
        ifc.flush    = 1'b0;
        ifc.load_en  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        ifc.fetch_en = 1'b1;
        ifc.address  = a;
        step();
        ifc.fetch_en = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (ifc.instruction !== NOP || ifc.instr_valid !== 1'b0 || ifc.addr_fault !== 1'b0
            || ifc.fetch_count !== 16'd0 || ifs.fetch_count !== 2'd0) begin
            fails++;
            $display("FAIL reset_state: got instr=%h vld=%b flt=%b cnt=%0d cnt2=%0d, want %h 0 0 0 0",
                     ifc.instruction, ifc.instr_valid, ifc.addr_fault, ifc.fetch_count, ifs.fetch_count, NOP);
        end
        reset = 1'b0;
    endtask

    task automatic test_load_fetch();
        prog[0] = 32'h0448_C000; prog[1] = 32'h0504_8000;
        prog[2] = 32'h0911_0000; prog[3] = 32'h0D94_4000;
        set_idle();
        for (int i = 0; i < 4; i++) begin
            ifc.load_en   = 1'b1;
            ifc.load_addr = 32'(i * 4);
            ifc.load_data = prog[i];
            step();
        end
        ifc.load_en  = 1'b0;
        ifc.fetch_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifc.address = 32'(i * 4);
            step();
            tests++;
            if (ifc.instruction !== prog[i] || ifc.instr_valid !== 1'b1 || ifc.addr_fault !== 1'b0) begin
                fails++;
                $display("FAIL b2b_fetch[%0d]: got instr=%h vld=%b flt=%b, want %h 1 0",
                         i, ifc.instruction, ifc.instr_valid, ifc.addr_fault, prog[i]);
            end
        end
        ifc.fetch_en = 1'b0;
        tests++;
        if (ifc.fetch_count !== 16'd4) begin
            fails++;
            $display("FAIL b2b_count: got %0d, want 4", ifc.fetch_count);
        end
    endtask

    task automatic test_stall();
        set_idle();
        fetch(32'd4);
        ifc.stall    = 1'b1;
        ifc.fetch_en = 1'b1;
        ifc.address  = 32'd8;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (ifc.instruction !== 32'h0504_8000 || ifc.instr_valid !== 1'b1
                || ifc.addr_fault !== 1'b0 || ifc.fetch_count !== 16'd5) begin
                fails++;
                $display("FAIL stall_hold[%0d]: got instr=%h vld=%b flt=%b cnt=%0d, want 05048000 1 0 5",
                         i, ifc.instruction, ifc.instr_valid, ifc.addr_fault, ifc.fetch_count);
            end
        end
        ifc.stall = 1'b0;
        step();
        ifc.fetch_en = 1'b0;
        tests++;
        if (ifc.instruction !== 32'h0911_0000 || ifc.instr_valid !== 1'b1 || ifc.fetch_count !== 16'd6) begin
            fails++;
            $display("FAIL stall_release: got instr=%h vld=%b cnt=%0d, want 09110000 1 6",
                     ifc.instruction, ifc.instr_valid, ifc.fetch_count);
        end
    endtask

    task automatic test_flush();
        set_idle();
        fetch(32'd4);
        ifc.stall    = 1'b1;
        ifc.flush    = 1'b1;
        ifc.fetch_en = 1'b1;
        ifc.address  = 32'd12;
        step();
        set_idle();
        tests++;
        if (ifc.instruction !== NOP || ifc.instr_valid !== 1'b0 || ifc.addr_fault !== 1'b0
            || ifc.fetch_count !== 16'd7) begin
            fails++;
            $display("FAIL flush_over_stall: got instr=%h vld=%b flt=%b cnt=%0d, want %h 0 0 7",
                     ifc.instruction, ifc.instr_valid, ifc.addr_fault, ifc.fetch_count, NOP);
        end
    endtask

    task automatic test_fault();
        logic [31:0] bad [2];
        bad[0] = 32'd6;
        bad[1] = 32'(DEPTH * 4);
        set_idle();
        for (int i = 0; i < 2; i++) begin
            fetch(bad[i]);
            tests++;
            if (ifc.instruction !== NOP || ifc.instr_valid !== 1'b0 || ifc.addr_fault !== 1'b1
                || ifc.fetch_count !== 16'd7) begin
                fails++;
                $display("FAIL fault_addr_%0d: got instr=%h vld=%b flt=%b cnt=%0d, want %h 0 1 7",
                         bad[i], ifc.instruction, ifc.instr_valid, ifc.addr_fault, ifc.fetch_count, NOP);
            end
        end
        ifc.load_en   = 1'b1;
        ifc.load_addr = 32'(DEPTH * 4);
        ifc.load_data = 32'hFFFF_FFFF;
        step();
        ifc.load_en = 1'b0;
        fetch(32'd0);
        tests++;
        if (ifc.instruction !== 32'h0448_C000 || ifc.instr_valid !== 1'b1 || ifc.addr_fault !== 1'b0) begin
            fails++;
            $display("FAIL oob_load_dropped: got instr=%h vld=%b flt=%b, want 0448c000 1 0",
                     ifc.instruction, ifc.instr_valid, ifc.addr_fault);
        end
    endtask

    task automatic test_rdw();
        set_idle();
        ifc.load_en   = 1'b1;
        ifc.load_addr = 32'd16;
        ifc.load_data = 32'hDEAD_BEEF;
        fetch(32'd16);
        ifc.load_en = 1'b0;
        tests++;
        if (ifc.instruction !== 32'hDEAD_BEEF || ifc.instr_valid !== 1'b1) begin
            fails++;
            $display("FAIL rdw_write_first: got instr=%h vld=%b, want deadbeef 1",
                     ifc.instruction, ifc.instr_valid);
        end
        fetch(32'd16);
        tests++;
        if (ifc.instruction !== 32'hDEAD_BEEF || ifc.instr_valid !== 1'b1) begin
            fails++;
            $display("FAIL rdw_stored: got instr=%h vld=%b, want deadbeef 1",
                     ifc.instruction, ifc.instr_valid);
        end
    endtask

    task automatic test_async_reset();
        set_idle();
        fetch(32'd8);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        tests++;
        if (ifc.instruction !== NOP || ifc.instr_valid !== 1'b0 || ifc.addr_fault !== 1'b0
            || ifc.fetch_count !== 16'd0 || ifs.fetch_count !== 2'd0) begin
            fails++;
            $display("FAIL async_reset: got instr=%h vld=%b flt=%b cnt=%0d cnt2=%0d, want %h 0 0 0 0",
                     ifc.instruction, ifc.instr_valid, ifc.addr_fault, ifc.fetch_count, ifs.fetch_count, NOP);
        end
        reset = 1'b0;
        fetch(32'd0);
        tests++;
        if (ifc.instruction !== 32'h0448_C000 || ifc.instr_valid !== 1'b1 || ifc.fetch_count !== 16'd1) begin
            fails++;
            $display("FAIL refetch_after_reset: got instr=%h vld=%b cnt=%0d, want 0448c000 1 1",
                     ifc.instruction, ifc.instr_valid, ifc.fetch_count);
        end
    endtask

    task automatic test_saturate();
        set_idle();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) fetch(32'(i * 4));
        tests++;
        if (ifs.fetch_count !== 2'd3 || ifc.fetch_count !== 16'd5) begin
            fails++;
            $display("FAIL count_saturate: got cnt2=%0d cnt=%0d, want 3 5", ifs.fetch_count, ifc.fetch_count);
        end
    endtask

    task automatic test_random();
        set_idle();
        for (int i = 0; i < DEPTH; i++) begin
            ifc.load_en   = 1'b1;
            ifc.load_addr = 32'(i * 4);
            ifc.load_data = $urandom;
            step();
        end
        for (int n = 0; n < 400; n++) begin
            ifc.fetch_en = ($urandom_range(0, 9) < 7);
            ifc.stall    = ($urandom_range(0, 99) < 15);
            ifc.flush    = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 9) < 8) ifc.address = 32'($urandom_range(0, DEPTH + 4) * 4);
            else                          ifc.address = 32'($urandom_range(0, 1023));
            ifc.load_en   = ($urandom_range(0, 9) < 2);
            ifc.load_addr = ($urandom_range(0, 3) == 0) ? ifc.address
                                                         : 32'($urandom_range(0, (DEPTH + 8) * 4));
            ifc.load_data = $urandom;
            step();
            tests++;
            if (ifc.instruction !== e_instr || ifc.instr_valid !== e_vld || ifc.addr_fault !== e_flt
                || ifc.fetch_count !== 16'(e_cnt) || ifs.fetch_count !== 2'(e_cnt2)) begin
                fails++;
                $display("FAIL random[%0d]: got instr=%h vld=%b flt=%b cnt=%0d cnt2=%0d, want %h %b %b %0d %0d",
                         n, ifc.instruction, ifc.instr_valid, ifc.addr_fault, ifc.fetch_count,
                         ifs.fetch_count, e_instr, e_vld, e_flt, e_cnt, e_cnt2);
            end
        end
        set_idle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        reset         = 1'b1;
        ifc.address   = 32'h0;
        ifc.load_addr = 32'h0;
        ifc.load_data = 32'h0;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_fetch();
        test_stall();
        test_flush();
        test_fault();
        test_rdw();
        test_async_reset();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
